// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers and end-value constants for Gray-coded counters.
// Functions work on MAX_W-bit vectors; narrower users zero-extend in and truncate out.
package gray_pkg;

    localparam int unsigned MAX_W = 32;
    localparam logic [MAX_W-1:0] BIN_ZERO = '0;

    // All-ones value for an n-bit counter, right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] bin_max(input int unsigned n);
        return {MAX_W{1'b1}} >> (MAX_W - n);
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_updn_if.sv
// Control and status bundle of the Gray up/down counter; master drives controls.
interface gray_counter_updn_if #(parameter int unsigned N = 4);

    logic         clr;
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_gray;
    logic [N-1:0] gray_count;
    logic [N-1:0] bin_count;
    logic [N-1:0] bit_chg;
    logic         tc;
    logic         wrap;

    modport master (
        output clr, en, up, load, load_gray,
        input  gray_count, bin_count, bit_chg, tc, wrap
    );

    modport slave (
        input  clr, en, up, load, load_gray,
        output gray_count, bin_count, bit_chg, tc, wrap
    );

endinterface

// File: rtl/gray_counter_updn_gray_to_bin.sv
// Combinational Gray-to-binary decoder, zero latency, no flow control.
// Shared with other blocks that decode Gray pointers.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    assign bin = N'(gray2bin(MAX_W'(gray)));

endmodule

// File: rtl/gray_counter_updn.sv
// N-bit Gray up/down counter with clear, Gray load, wrap/saturate ends; 1-cycle latency.
// No backpressure: en is a level qualifier, one step per enabled edge.
module gray_counter_updn
    import gray_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    gray_counter_updn_if.slave  cif
);

    localparam logic [N-1:0] BIN_MAX = N'(bin_max(N));
    localparam logic [N-1:0] BIN_MIN = N'(BIN_ZERO);

    logic [N-1:0] load_bin;
    logic [N-1:0] bin_nxt;
    logic [N-1:0] gray_nxt;
    logic         wrap_nxt;

    gray_to_bin #(.N(N)) u_load_dec (
        .gray (cif.load_gray),
        .bin  (load_bin)
    );

    // End-of-range steps rely on natural N-bit modulo arithmetic for the wrap case.
    always_comb begin
        bin_nxt  = cif.bin_count;
        wrap_nxt = 1'b0;
        if (cif.clr) begin
            bin_nxt = BIN_MIN;
        end else if (cif.load) begin
            bin_nxt = load_bin;
        end else if (cif.en) begin
            if (cif.up) begin
                if (cif.bin_count != BIN_MAX || !SATURATE) begin
                    bin_nxt  = cif.bin_count + 1'b1;
                    wrap_nxt = (cif.bin_count == BIN_MAX);
                end
            end else begin
                if (cif.bin_count != BIN_MIN || !SATURATE) begin
                    bin_nxt  = cif.bin_count - 1'b1;
                    wrap_nxt = (cif.bin_count == BIN_MIN);
                end
            end
        end
        gray_nxt = N'(bin2gray(MAX_W'(bin_nxt)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cif.bin_count  <= '0;
            cif.gray_count <= '0;
            cif.bit_chg    <= '0;
            cif.wrap       <= 1'b0;
        end else begin
            cif.bin_count  <= bin_nxt;
            cif.gray_count <= gray_nxt;
            cif.bit_chg    <= cif.gray_count ^ gray_nxt;
            cif.wrap       <= wrap_nxt;
        end
    end

    assign cif.tc = cif.up ? (cif.bin_count == BIN_MAX) : (cif.bin_count == BIN_MIN);

endmodule

// File: doc/gray_counter_updn.md
# gray_counter_updn

Parametrised N-bit Gray-code up/down counter with enable, synchronous clear, parallel Gray load, selectable wrap or saturate at the range ends, and terminal-count and wrap flags. It replaces the fixed 4-bit free-running Gray counter in the counter library. Typical users are FIFO pointers, position encoders and clock-domain-crossing counters, where only one output bit may change per step. It also provides the binary equivalent and a one-hot changed-bit vector for downstream checking.

## Interface
- N, 4, counter width in bits; N >= 2.
- SATURATE, 0, selects the behaviour at the range ends: 0 wraps around, 1 holds at the end value.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high. This polarity and synchronicity are fixed.
- clr  input  1  synchronous clear to zero.
- en  input  1  count enable; advances the counter one step.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load.
- load_gray  input  N  Gray-coded value to load.
- gray_count  output  N  registered Gray count.
- bin_count  output  N  registered binary equivalent of gray_count.
- bit_chg  output  N  registered one-hot vector marking the gray_count bit that changed on the last update; all zeros if gray_count did not change.
- tc  output  1  combinational terminal-count flag: 1 when bin_count is 2^N-1 with up=1, or 0 with up=0.
- wrap  output  1  registered one-cycle pulse marking that the last update wrapped around.

## Operation
- State is bin_count. Rule: gray_count = bin_count ^ (bin_count >> 1).
  - Both outputs are registered on the same edge and always match each other; there is no one-cycle skew between them.
- Priority on each clock edge, highest first: reset, clr, load, en, hold.
- reset (asynchronous, active-high):
  - gray_count, bin_count, bit_chg and wrap go to 0 at once.
  - tc then follows up (see the tc definition above).
- clr: bin_count <= 0; wrap <= 0. bit_chg is computed normally (it may have more than one bit set).
- load: bin_count <= gray2bin(load_gray); wrap <= 0. Any load_gray value is legal.
- en=1 and up=1:
  - bin_count < 2^N-1: increment.
  - bin_count = 2^N-1 and SATURATE=0: go to 0 and set wrap=1.
  - bin_count = 2^N-1 and SATURATE=1: hold; wrap stays 0.
- en=1 and up=0:
  - bin_count > 0: decrement.
  - bin_count = 0 and SATURATE=0: go to 2^N-1 and set wrap=1.
  - bin_count = 0 and SATURATE=1: hold; wrap stays 0.
- en=0, or a saturated hold: state is unchanged, bit_chg <= 0, wrap <= 0.
- bit_chg <= old gray_count ^ new gray_count.
  - For every en step this has exactly one bit set, including the wrap step.
  - After clr or load it is the raw XOR of old and new values.
- All arithmetic is N-bit unsigned. Wrap-around relies on the natural modulo 2^N; no wider intermediate is kept.
- Changing up while en=1 takes effect on the next edge, with no penalty cycle.

## Timing
- Latency is one cycle: a control input sampled on edge k is visible on the outputs after edge k.
- tc is combinational from bin_count and up, with no added register. It is valid in the same cycle that up changes.
- wrap and bit_chg are valid for exactly the one cycle that follows the update that caused them.
- If reset is asserted in the middle of a count sequence, the outputs clear immediately and asynchronously.
- reset deassertion is synchronised by the integrating design; the counter starts from 0 on the first edge after release.
- The counter has no handshake. en is a level-sensitive qualifier, and the counter advances one step per enabled edge.

## Structure
- Package gray_pkg holds:
  - function bin2gray(N-bit);
  - function gray2bin(N-bit), built as a prefix XOR from the MSB down;
  - the localparam forms of the end values.
- Sub-module gray_to_bin (combinational, parameter N) converts load_gray. It is reused by other blocks that decode Gray pointers.
- The top level holds a single always block for the registers plus a combinational next-state block.

## Test plan
- N=4, wrap mode: reset, then en=1, up=1 for 16 edges. gray_count follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 and then returns to 0; wrap pulses on that 16th edge; popcount(bit_chg)=1 on every step.
- N=4, wrap mode, down count: starting from 0 with en=1, up=0, one edge gives bin_count=F and gray_count=8 with wrap=1. tc=1 at 0 with up=0, and tc=1 at F with up=1.
- N=4, SATURATE=1: count up to F, then hold en=1 for 3 more edges. gray_count stays 8, bit_chg=0, wrap=0 and tc=1 throughout.
- Priority: at the same edge apply clr=1, load=1 with load_gray=4'hC, and en=1; the result is 0. Next apply load=1 with load_gray=4'hC and en=1; the result is bin_count=8, gray_count=C. Then apply en=1, up=0; the result is bin_count=7, gray_count=4, bit_chg=8.
- Asynchronous reset: assert reset between edges in the middle of a count. The outputs read 0 before the next edge, and counting resumes from 0 after release.
- Random regression, N=8, both SATURATE settings: check gray_count == bin2gray(bin_count) every cycle, check against a reference model, and check that each en step changes exactly one bit.
